// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters with registered
// lookups, mispredict flush/redirect generation and resolve/mispredict statistics.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             lookup_valid_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  input  logic             resolve_valid_i,
  input  logic [31:0]      resolve_pc_i,
  input  logic             resolve_taken_i,
  input  logic             resolve_pred_i,
  input  logic [31:0]      resolve_target_i,
  output logic             flush_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  // Handshake: lookup and resolve are valid-only channels with no backpressure.
  // A request is consumed at every rising edge where its valid is high; pred_valid_o
  // and flush_o are one-cycle response pulses that the consumer must take as they come.

  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic             mispredict;
  logic [31:0]      redirect_d;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic             flush_q;
  logic [31:0]      redirect_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic             unused_pc_bits;

  assign lookup_idx  = lookup_pc_i[IDX_W+1:2];
  assign resolve_idx = resolve_pc_i[IDX_W+1:2];
  assign mispredict  = resolve_valid_i && (resolve_taken_i != resolve_pred_i);
  assign redirect_d  = resolve_taken_i ? resolve_target_i : (resolve_pc_i + 32'd4);

  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

  // Counter table; a lookup in the same cycle sees the value before this write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (resolve_valid_i) begin
      if (resolve_taken_i) begin
        if (bht[resolve_idx] != 2'b11) bht[resolve_idx] <= bht[resolve_idx] + 2'd1;
      end else begin
        if (bht[resolve_idx] != 2'b00) bht[resolve_idx] <= bht[resolve_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= 32'd0;
    end else begin
      pred_valid_q <= lookup_valid_i;
      pred_taken_q <= lookup_valid_i & bht[lookup_idx][1];
      flush_q      <= mispredict;
      redirect_q   <= mispredict ? redirect_d : 32'd0;
    end
  end

  // Statistics counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve_valid_i && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (mispredict && (mispred_cnt_q != '1))     mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  // A flush kills the response of the lookup that was in flight alongside it.
  assign pred_valid_o  = pred_valid_q & ~flush_q;
  assign pred_taken_o  = pred_taken_q;
  assign flush_o       = flush_q;
  assign redirect_pc_o = redirect_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, mid-operation
// reset sequence, and randomized traffic against a behavioural reference model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int CNT_W   = 16;
  localparam int EXP_W   = 3 + 32 + 2 * CNT_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             lookup_valid_i = 1'b0;
  logic [31:0]      lookup_pc_i = 32'd0;
  logic             pred_valid_o;
  logic             pred_taken_o;
  logic             resolve_valid_i = 1'b0;
  logic [31:0]      resolve_pc_i = 32'd0;
  logic             resolve_taken_i = 1'b0;
  logic             resolve_pred_i = 1'b0;
  logic [31:0]      resolve_target_i = 32'd0;
  logic             flush_o;
  logic [31:0]      redirect_pc_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  always #5 clk_i = ~clk_i;

  branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i), .resolve_pred_i(resolve_pred_i),
    .resolve_target_i(resolve_target_i),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: counter strength per table slot plus plain integer statistics.
  int m_ctr [ENTRIES];
  int m_branches;
  int m_mispreds;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
    m_branches = 0;
    m_mispreds = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic lv, input logic [31:0] lpc, input logic rv,
                       input logic [31:0] rpc, input logic rt, input logic rp,
                       input logic [31:0] tgt);
    lookup_valid_i   = lv;
    lookup_pc_i      = lpc;
    resolve_valid_i  = rv;
    resolve_pc_i     = rpc;
    resolve_taken_i  = rt;
    resolve_pred_i   = rp;
    resolve_target_i = tgt;
  endtask

  task automatic compare_expected(input string tag);
    logic [EXP_W-1:0] e;
    e = exp_q.pop_front();
    check({tag, " pred_valid"}, {31'd0, pred_valid_o}, {31'd0, e[EXP_W-1]});
    check({tag, " pred_taken"}, {31'd0, pred_taken_o}, {31'd0, e[EXP_W-2]});
    check({tag, " flush"},      {31'd0, flush_o},      {31'd0, e[EXP_W-3]});
    check({tag, " redirect"},   redirect_pc_o,         e[EXP_W-4 -: 32]);
    check({tag, " branch_cnt"}, 32'(branch_cnt_o),     32'(e[2*CNT_W-1 -: CNT_W]));
    check({tag, " mispred_cnt"}, 32'(mispred_cnt_o),   32'(e[CNT_W-1:0]));
  endtask

  // One cycle of traffic: model predicts the post-edge outputs, DUT is sampled 1ns after the edge.
  task automatic step(input string tag, input logic lv, input logic [31:0] lpc, input logic rv,
                      input logic [31:0] rpc, input logic rt, input logic rp,
                      input logic [31:0] tgt);
    int   li;
    int   ri;
    logic mis;
    logic epv;
    logic ept;
    logic [31:0] erd;
    li  = int'((lpc >> 2) & 32'(ENTRIES - 1));
    ri  = int'((rpc >> 2) & 32'(ENTRIES - 1));
    mis = rv && (rt != rp);
    ept = lv && (m_ctr[li] >= 2);
    epv = lv && !mis;
    erd = !mis ? 32'd0 : (rt ? tgt : rpc + 32'd4);
    if (rv) begin
      if (rt) m_ctr[ri] = (m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1;
      else    m_ctr[ri] = (m_ctr[ri] == 0) ? 0 : m_ctr[ri] - 1;
      if (m_branches < CNT_MAX) m_branches++;
      if (mis && m_mispreds < CNT_MAX) m_mispreds++;
    end
    exp_q.push_back({epv, ept, mis, erd, CNT_W'(m_branches), CNT_W'(m_mispreds)});
    drive(lv, lpc, rv, rpc, rt, rp, tgt);
    @(posedge clk_i);
    #1;
    compare_expected(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pred_valid"}, {31'd0, pred_valid_o}, 32'd0);
    check({tag, " pred_taken"}, {31'd0, pred_taken_o}, 32'd0);
    check({tag, " flush"},      {31'd0, flush_o},      32'd0);
    check({tag, " redirect"},   redirect_pc_o,         32'd0);
    check({tag, " branch_cnt"}, 32'(branch_cnt_o),     32'd0);
    check({tag, " mispred_cnt"}, 32'(mispred_cnt_o),   32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        lv;
    logic [31:0] lpc;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic        rp;
    logic [31:0] tgt;
    logic        e_pv;
    logic        e_pt;
    logic        e_fl;
    logic [31:0] e_rd;
    logic [15:0] e_b;
    logic [15:0] e_m;
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  initial begin
    //            lv  lpc           rv  rpc           rt  rp  tgt           pv  pt  fl  rd            b      m
    tbl[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    16'd0, 16'd0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 32'h100,      1'b1, 1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    16'd1, 16'd0};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 32'h100,      1'b1, 1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    16'd2, 16'd0};
    tbl[3]  = '{1'b1, 32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0,    16'd2, 16'd0};
    tbl[4]  = '{1'b0, 32'h0,   1'b1, 32'h200,      1'b1, 1'b0, 32'h400,  1'b0, 1'b0, 1'b1, 32'h400,  16'd3, 16'd1};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    16'd3, 16'd1};
    tbl[6]  = '{1'b0, 32'h0,   1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0,    16'd4, 16'd2};
    tbl[7]  = '{1'b0, 32'h0,   1'b1, 32'h300,      1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    16'd5, 16'd2};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 32'h300,      1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    16'd6, 16'd2};
    tbl[9]  = '{1'b1, 32'h300, 1'b1, 32'h300,      1'b1, 1'b0, 32'h500,  1'b0, 1'b0, 1'b1, 32'h500,  16'd7, 16'd3};
    tbl[10] = '{1'b1, 32'h300, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0,    16'd7, 16'd3};
    tbl[11] = '{1'b0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    16'd7, 16'd3};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 32'h10,       1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b1, 32'h1000, 16'd8, 16'd4};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 32'h20,       1'b0, 1'b1, 32'h0,    1'b0, 1'b0, 1'b1, 32'h24,   16'd9, 16'd5};
    tbl[14] = '{1'b0, 32'h0,   1'b0, 32'hDEAD,     1'b1, 1'b0, 32'hBEEF, 1'b0, 1'b0, 1'b0, 32'h0,    16'd9, 16'd5};
  end

  // ---------------- main test ----------------
  initial begin
    logic [31:0] lpc;
    logic [31:0] rpc;
    string tag;

    #1;
    check_all_zero("reset_hold");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Directed vectors, one row per clock edge.
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].lv, tbl[i].lpc, tbl[i].rv, tbl[i].rpc, tbl[i].rt, tbl[i].rp, tbl[i].tgt);
      @(posedge clk_i);
      #1;
      tag = $sformatf("row%0d", i);
      check({tag, " pred_valid"}, {31'd0, pred_valid_o}, {31'd0, tbl[i].e_pv});
      check({tag, " pred_taken"}, {31'd0, pred_taken_o}, {31'd0, tbl[i].e_pt});
      check({tag, " flush"},      {31'd0, flush_o},      {31'd0, tbl[i].e_fl});
      check({tag, " redirect"},   redirect_pc_o,         tbl[i].e_rd);
      check({tag, " branch_cnt"}, 32'(branch_cnt_o),     32'(tbl[i].e_b));
      check({tag, " mispred_cnt"}, 32'(mispred_cnt_o),   32'(tbl[i].e_m));
    end

    // Reset arriving while a flush and a lookup response are pending.
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80);
    @(posedge clk_i);
    #1;
    check("midrst pre flush", {31'd0, flush_o}, 32'd1);
    check("midrst pre redirect", redirect_pc_o, 32'h80);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_i = 1'b1;
    #1;
    check_all_zero("midrst asserted");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    step("post_rst idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Every slot must be weak-not-taken: one taken step tips it to predict taken.
    for (int i = 0; i < ENTRIES; i++) begin
      step($sformatf("init%0d train", i), 1'b0, 32'h0, 1'b1, 32'(i * 4), 1'b1, 1'b1, 32'h0);
      step($sformatf("init%0d look", i), 1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check($sformatf("init%0d taken", i), {31'd0, pred_taken_o}, 32'd1);
    end

    // Five not-taken resolves saturate at strong-not-taken; one taken must not tip it.
    for (int i = 0; i < 5; i++) begin
      step($sformatf("sat_nt%0d", i), 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
    end
    step("sat_look", 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("sat_up", 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h44);
    step("sat_look2", 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("sat stays NT", {31'd0, pred_taken_o}, 32'd0);

    // Randomized traffic over a small PC set so lookups and updates collide often.
    for (int n = 0; n < 3000; n++) begin
      lpc = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFFFFFC;
      else rpc = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, ENTRIES - 1) << 2));
      step($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), rpc,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
